// File: rtl/legv8_control_unit_pkg.sv
// legv8_ctrl_pkg: shared types and constants for the LEGv8 multicycle control unit.
// Holds the sequencer state enum, opcode match values, ALU function codes,
// datapath select encodings and ControlWord bit offsets.
package legv8_ctrl_pkg;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_LINK, ST_HALT} state_t;

  // Opcode match values, keyed by how many top bits of the instruction they cover
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;

  typedef enum logic [4:0] {
    FS_AND   = 5'b00000,
    FS_ORR   = 5'b00100,
    FS_ADD   = 5'b01000,
    FS_SUB   = 5'b01001,
    FS_EOR   = 5'b01100,
    FS_PASSB = 5'b10100
  } fs_t;

  typedef enum logic       {AS_ALU = 1'b0, AS_PC = 1'b1} as_t;
  typedef enum logic [1:0] {DS_ALU = 2'b00, DS_B = 2'b01, DS_PC = 2'b10, DS_MEM = 2'b11} ds_t;
  typedef enum logic [1:0] {PS_HOLD = 2'b00, PS_INC4 = 2'b01, PS_OFFSET = 2'b10, PS_ALU = 2'b11} ps_t;

  // ControlWord layout (LSB offsets)
  localparam int CW_SB    = 0;
  localparam int CW_SA    = 5;
  localparam int CW_DA    = 10;
  localparam int CW_RW    = 15;
  localparam int CW_MW    = 16;
  localparam int CW_SIZE  = 17;
  localparam int CW_C0    = 19;
  localparam int CW_FS    = 20;
  localparam int CW_SL    = 25;
  localparam int CW_IL    = 26;
  localparam int CW_BSEL  = 27;
  localparam int CW_PCSEL = 28;
  localparam int CW_PS    = 29;
  localparam int CW_DS    = 31;
  localparam int CW_AS    = 33;

  // PC-relative offset: the PC was already advanced by 4 in FETCH, so take 4 back off.
  function automatic logic [63:0] pc_rel(input logic [63:0] sext_imm);
    return (sext_imm << 2) - 64'd4;
  endfunction

endpackage

// File: rtl/legv8_control_unit_cond_eval.sv
// legv8_cond_eval: combinational B.cond evaluator.
// Ports: cond[3:0] condition field, flags[3:0] = {V,C,N,Z}, taken = branch condition holds.
// Codes 1110 (AL) and 1111 both evaluate as always-taken.
module legv8_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic v, c, n, z;
  assign {v, c, n, z} = flags;

  always_comb begin
    case (cond)
      4'h0:    taken = z;                // EQ
      4'h1:    taken = ~z;               // NE
      4'h2:    taken = c;                // HS
      4'h3:    taken = ~c;               // LO
      4'h4:    taken = n;                // MI
      4'h5:    taken = ~n;               // PL
      4'h6:    taken = v;                // VS
      4'h7:    taken = ~v;               // VC
      4'h8:    taken = c & ~z;           // HI
      4'h9:    taken = ~c | z;           // LS
      4'hA:    taken = ~(n ^ v);         // GE
      4'hB:    taken = n ^ v;            // LT
      4'hC:    taken = ~z & ~(n ^ v);    // GT
      4'hD:    taken = z | (n ^ v);      // LE
      default: taken = 1'b1;             // AL
    endcase
  end

endmodule

// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multicycle FETCH/EXEC(/LINK) sequencer for the LEGv8 datapath.
// Ports: clock/reset (async, active-high), IR_out instruction, status {V,C,N,Z,liveZ};
// outputs ControlWord (combinational from state/IR/status), constant, halted, retired count.
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter logic [4:0] LINK_REG      = 5'd30,
  parameter logic [4:0] ZERO_REG      = 5'd31,
  parameter bit         HALT_ON_UNDEF = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_out,
  input  logic [4:0]  status,
  output logic [33:0] ControlWord,
  output logic [63:0] constant,
  output logic        halted,
  output logic [31:0] retired
);

  state_t      state, nxt;
  logic        retire;
  logic [33:0] cw;
  logic [63:0] k;
  logic        taken;
  logic        is_r, is_i, s_form;
  fs_t         r_fs;

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [8:0]  op9;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;
  logic [63:0] imm12, imm9, imm16, off19, off26;

  assign op11  = IR_out[31:21];
  assign op10  = IR_out[31:22];
  assign op9   = IR_out[31:23];
  assign op8   = IR_out[31:24];
  assign op6   = IR_out[31:26];
  assign rd    = IR_out[4:0];
  assign rn    = IR_out[9:5];
  assign rm    = IR_out[20:16];
  assign imm12 = {52'd0, IR_out[21:10]};
  assign imm9  = {{55{IR_out[20]}}, IR_out[20:12]};
  assign imm16 = {48'd0, IR_out[20:5]} << {IR_out[22:21], 4'b0000};
  assign off19 = pc_rel({{45{IR_out[23]}}, IR_out[23:5]});
  assign off26 = pc_rel({{38{IR_out[25]}}, IR_out[25:0]});

  assign is_i   = (op10 == OP_ADDI) || (op10 == OP_ADDIS) || (op10 == OP_SUBI) || (op10 == OP_SUBIS);
  assign s_form = (op11 == OP_ADDS) || (op11 == OP_SUBS) || (op10 == OP_ADDIS) || (op10 == OP_SUBIS);

  legv8_cond_eval u_cond (
    .cond  (IR_out[3:0]),
    .flags (status[4:1]),
    .taken (taken)
  );

  always_comb begin
    is_r = 1'b1;
    r_fs = FS_ADD;
    case (op11)
      OP_ADD, OP_ADDS: r_fs = FS_ADD;
      OP_SUB, OP_SUBS: r_fs = FS_SUB;
      OP_AND:          r_fs = FS_AND;
      OP_ORR:          r_fs = FS_ORR;
      OP_EOR:          r_fs = FS_EOR;
      default:         is_r = 1'b0;
    endcase
  end

  always_comb begin
    cw     = '0;
    k      = '0;
    nxt    = state;
    retire = 1'b0;
    cw[CW_PCSEL]   = 1'b0;  // PS alone steers the PC source
    cw[CW_DA +: 5] = ZERO_REG;
    cw[CW_SA +: 5] = ZERO_REG;
    cw[CW_SB +: 5] = ZERO_REG;
    case (state)
      ST_FETCH: begin
        cw[CW_AS]        = AS_PC;
        cw[CW_DS +: 2]   = DS_MEM;
        cw[CW_IL]        = 1'b1;
        cw[CW_PS +: 2]   = PS_INC4;
        cw[CW_SIZE +: 2] = 2'b10;
        nxt              = ST_EXEC;
      end
      ST_EXEC: begin
        nxt    = ST_FETCH;
        retire = 1'b1;
        if (is_r) begin
          cw[CW_SA +: 5] = rn;
          cw[CW_SB +: 5] = rm;
          cw[CW_DA +: 5] = rd;
          cw[CW_RW]      = 1'b1;
          cw[CW_FS +: 5] = r_fs;
          cw[CW_C0]      = (r_fs == FS_SUB);
          cw[CW_SL]      = s_form;
        end else if (is_i) begin
          cw[CW_SA +: 5] = rn;
          cw[CW_DA +: 5] = rd;
          cw[CW_BSEL]    = 1'b1;
          cw[CW_RW]      = 1'b1;
          cw[CW_FS +: 5] = IR_out[30] ? FS_SUB : FS_ADD;
          cw[CW_C0]      = IR_out[30];
          cw[CW_SL]      = s_form;
          k              = imm12;
        end else if ((op11 == OP_LDUR) || (op11 == OP_STUR)) begin
          cw[CW_AS]        = AS_ALU;
          cw[CW_FS +: 5]   = FS_ADD;
          cw[CW_BSEL]      = 1'b1;
          cw[CW_SA +: 5]   = rn;
          cw[CW_SIZE +: 2] = 2'b11;
          k                = imm9;
          if (op11 == OP_LDUR) begin
            cw[CW_DS +: 2] = DS_MEM;
            cw[CW_DA +: 5] = rd;
            cw[CW_RW]      = 1'b1;
          end else begin
            cw[CW_DS +: 2] = DS_B;
            cw[CW_SB +: 5] = rd;
            cw[CW_MW]      = 1'b1;
          end
        end else if (op9 == OP_MOVZ) begin
          cw[CW_FS +: 5] = FS_PASSB;
          cw[CW_BSEL]    = 1'b1;
          cw[CW_DA +: 5] = rd;
          cw[CW_RW]      = 1'b1;
          k              = imm16;
        end else if (op6 == OP_B) begin
          cw[CW_PS +: 2] = PS_OFFSET;
          k              = off26;
        end else if (op6 == OP_BL) begin
          // Capture the already-advanced PC as the link value; branch happens in LINK.
          cw[CW_DS +: 2] = DS_PC;
          cw[CW_DA +: 5] = LINK_REG;
          cw[CW_RW]      = 1'b1;
          nxt            = ST_LINK;
          retire         = 1'b0;
        end else if ((op8 == OP_CBZ) || (op8 == OP_CBNZ)) begin
          // Rt passes through the ALU so status[0] reflects Rt == 0 in this same cycle.
          cw[CW_SB +: 5] = rd;
          cw[CW_FS +: 5] = FS_PASSB;
          k              = off19;
          if (status[0] == (op8 == OP_CBZ)) cw[CW_PS +: 2] = PS_OFFSET;
        end else if (op8 == OP_BCOND) begin
          k = off19;
          if (taken) cw[CW_PS +: 2] = PS_OFFSET;
        end else if (HALT_ON_UNDEF) begin
          nxt    = ST_HALT;
          retire = 1'b0;
        end
      end
      ST_LINK: begin
        cw[CW_PS +: 2] = PS_OFFSET;
        k              = off26;
        nxt            = ST_FETCH;
        retire         = 1'b1;
      end
      ST_HALT: nxt = ST_HALT;
    endcase
    // XZR is never a real destination
    if (cw[CW_DA +: 5] == ZERO_REG) cw[CW_RW] = 1'b0;
  end

  assign ControlWord = cw;
  assign constant    = k;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_FETCH;
      retired <= '0;
      halted  <= 1'b0;
    end else begin
      state  <= nxt;
      halted <= (nxt == ST_HALT);
      if (retire) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_legv8_control_unit.sv
module tb_legv8_control_unit;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] IR_out = '0;
  logic [4:0]  status = '0;
  logic [33:0] ControlWord;
  logic [63:0] constant;
  logic        halted;
  logic [31:0] retired;

  legv8_control_unit dut (
    .clock       (clock),
    .reset       (reset),
    .IR_out      (IR_out),
    .status      (status),
    .ControlWord (ControlWord),
    .constant    (constant),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [33:0] cw;
    logic [63:0] k;
    logic        h;
    logic [31:0] r;
  } rec_t;

  rec_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          m_fetch = 1'b1;
  bit          m_link  = 1'b0;
  bit          m_halt  = 1'b0;
  logic [31:0] m_ret   = '0;

  function automatic logic [33:0] pack(input logic as_, input logic [1:0] ds, input logic [1:0] ps,
                                       input logic bsel, input logic il, input logic sl,
                                       input logic [4:0] fs, input logic c0, input logic [1:0] sz,
                                       input logic mw, input logic rw,
                                       input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
    return {as_, ds, ps, 1'b0, bsel, il, sl, fs, c0, sz, mw, rw, da, sa, sb};
  endfunction

  // Reference decode of one EXEC cycle. kind: 0 = retires, 1 = BL (link cycle follows), 2 = undefined
  function automatic void model_exec(input logic [31:0] ir, input logic [4:0] st,
                                     output logic [33:0] cw, output logic [63:0] k, output int kind);
    logic       as_, bsel, sl, c0, mw, rw, rt, v, c, n, z, base, take;
    logic [1:0] ds, ps, sz;
    logic [4:0] fs, da, sa, sb;
    longint     off19;
    as_ = 1'b0; bsel = 1'b0; sl = 1'b0; c0 = 1'b0; mw = 1'b0; rw = 1'b0; rt = 1'b0;
    ds = 2'b00; ps = 2'b00; sz = 2'b00; fs = 5'd0;
    da = 5'd31; sa = 5'd31; sb = 5'd31;
    k = '0; kind = 0;
    {v, c, n, z} = st[4:1];
    off19 = longint'($signed(ir[23:5])) * 4 - 4;
    case (ir[31:21])
      11'b10001011000: begin rt = 1'b1; fs = 5'b01000; end
      11'b10101011000: begin rt = 1'b1; fs = 5'b01000; sl = 1'b1; end
      11'b11001011000: begin rt = 1'b1; fs = 5'b01001; c0 = 1'b1; end
      11'b11101011000: begin rt = 1'b1; fs = 5'b01001; c0 = 1'b1; sl = 1'b1; end
      11'b10001010000: begin rt = 1'b1; fs = 5'b00000; end
      11'b10101010000: begin rt = 1'b1; fs = 5'b00100; end
      11'b11001010000: begin rt = 1'b1; fs = 5'b01100; end
      default: ;
    endcase
    if (rt) begin
      sa = ir[9:5]; sb = ir[20:16]; da = ir[4:0]; rw = 1'b1;
    end else if (ir[31:22] == 10'b1001000100 || ir[31:22] == 10'b1011000100 ||
                 ir[31:22] == 10'b1101000100 || ir[31:22] == 10'b1111000100) begin
      bsel = 1'b1; sa = ir[9:5]; da = ir[4:0]; rw = 1'b1;
      k = 64'(ir[21:10]);
      sl = ir[29];
      if (ir[30]) begin fs = 5'b01001; c0 = 1'b1; end else fs = 5'b01000;
    end else if (ir[31:21] == 11'b11111000010) begin
      fs = 5'b01000; bsel = 1'b1; sa = ir[9:5]; ds = 2'b11; sz = 2'b11; da = ir[4:0]; rw = 1'b1;
      k = longint'($signed(ir[20:12]));
    end else if (ir[31:21] == 11'b11111000000) begin
      fs = 5'b01000; bsel = 1'b1; sa = ir[9:5]; ds = 2'b01; sz = 2'b11; sb = ir[4:0]; mw = 1'b1;
      k = longint'($signed(ir[20:12]));
    end else if (ir[31:23] == 9'b110100101) begin
      fs = 5'b10100; bsel = 1'b1; da = ir[4:0]; rw = 1'b1;
      k = 64'(ir[20:5]) * (64'd1 << (16 * ir[22:21]));
    end else if (ir[31:26] == 6'b000101) begin
      ps = 2'b10;
      k = longint'($signed(ir[25:0])) * 4 - 4;
    end else if (ir[31:26] == 6'b100101) begin
      ds = 2'b10; da = 5'd30; rw = 1'b1; kind = 1;
    end else if (ir[31:25] == 7'b1011010) begin
      sb = ir[4:0]; fs = 5'b10100; k = off19;
      // CBZ branches on zero, CBNZ on non-zero
      if (st[0] != ir[24]) ps = 2'b10;
    end else if (ir[31:24] == 8'b01010100) begin
      k = off19;
      case (ir[3:1])
        3'd0:    base = z;
        3'd1:    base = c;
        3'd2:    base = n;
        3'd3:    base = v;
        3'd4:    base = c & ~z;
        3'd5:    base = (n == v);
        3'd6:    base = (n == v) & ~z;
        default: base = 1'b1;
      endcase
      take = (ir[0] && ir[3:1] != 3'b111) ? ~base : base;
      if (take) ps = 2'b10;
    end else begin
      kind = 2;
    end
    if (da == 5'd31) rw = 1'b0;
    cw = pack(as_, ds, ps, bsel, 1'b0, sl, fs, c0, sz, mw, rw, da, sa, sb);
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // Monitor: the DUT presents a word every cycle; compare mid-cycle against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (exp_q.size() > 0) begin
        rec_t e;
        e = exp_q.pop_front();
        check("control_word", 64'(ControlWord), 64'(e.cw));
        check("constant", constant, e.k);
        check("halted", 64'(halted), 64'(e.h));
        check("retired", 64'(retired), 64'(e.r));
      end
    end
  end

  task automatic step(input logic rst, input logic [31:0] ir, input logic [4:0] st);
    rec_t        e;
    logic [33:0] cw;
    logic [63:0] k;
    int          kind;
    @(posedge clock);
    #1;
    reset  = rst;
    IR_out = ir;
    status = st;
    e.h = m_halt;
    e.r = m_ret;
    e.k = '0;
    if (rst) begin
      m_fetch = 1'b1; m_link = 1'b0; m_halt = 1'b0; m_ret = '0;
      e.h = 1'b0; e.r = '0;
      e.cw = pack(1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
    end else if (m_halt) begin
      e.cw = pack(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
    end else if (m_fetch) begin
      e.cw = pack(1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
      m_fetch = 1'b0;
    end else if (m_link) begin
      e.cw = pack(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
      e.k = longint'($signed(ir[25:0])) * 4 - 4;
      m_link = 1'b0; m_fetch = 1'b1; m_ret = m_ret + 1;
    end else begin
      model_exec(ir, st, cw, k, kind);
      e.cw = cw;
      e.k  = k;
      case (kind)
        1:       m_link = 1'b1;
        2:       m_halt = 1'b1;
        default: begin m_fetch = 1'b1; m_ret = m_ret + 1; end
      endcase
    end
    exp_q.push_back(e);
  endtask

  // One whole instruction: FETCH (random flags), EXEC, and LINK when the model expects it
  task automatic instr(input logic [31:0] ir, input logic [4:0] st);
    if (!m_halt && m_fetch) step(1'b0, ir, 5'($urandom));
    step(1'b0, ir, st);
    if (m_link) step(1'b0, ir, st);
  endtask

  function automatic logic [31:0] gen_instr();
    case ($urandom_range(0, 15))
      0:  return {11'b10001011000, 21'($urandom)};
      1:  return {11'b10101011000, 21'($urandom)};
      2:  return {11'b11001011000, 21'($urandom)};
      3:  return {11'b11101011000, 21'($urandom)};
      4:  return {11'b10001010000, 21'($urandom)};
      5:  return {11'b10101010000, 21'($urandom)};
      6:  return {11'b11001010000, 21'($urandom)};
      7:  return {1'b1, 2'($urandom), 7'b1000100, 22'($urandom)};
      8:  return {11'b11111000010, 21'($urandom)};
      9:  return {11'b11111000000, 21'($urandom)};
      10: return {9'b110100101, 23'($urandom)};
      11: return {6'b000101, 26'($urandom)};
      12: return {6'b100101, 26'($urandom)};
      13: return {7'b1011010, 25'($urandom)};
      14: return {8'b01010100, 24'($urandom)};
      default: return {11'b10001011000, 16'($urandom), 5'd31};
    endcase
  endfunction

  initial begin
    step(1'b1, 32'h0, 5'h0);
    step(1'b1, 32'h0, 5'h0);
    instr(32'h91001441, 5'h00);            // ADDI X1,X2,#5
    instr(32'hF84080A4, 5'h00);            // LDUR X4,[X5,#8]
    instr(32'hF80080A4, 5'h00);            // STUR X4,[X5,#8]
    instr(32'h14000003, 5'h00);            // B +3
    instr(32'h94000003, 5'h00);            // BL +3
    instr(32'hB4000043, 5'h01);            // CBZ taken
    instr(32'hB4000043, 5'h00);            // CBZ not taken
    instr(32'h54000040, 5'h02);            // B.EQ, Z=1
    instr(32'h54000040, 5'h00);            // B.EQ, Z=0
    instr(32'hD2A00021, 5'h00);            // MOVZ X1,#1,LSL #16
    instr(32'hCB030041, 5'h00);            // SUB X1,X2,X3
    instr(32'hB100045F, 5'h00);            // ADDIS XZR,X2,#1 (write suppressed)
    // reset in the middle of an instruction
    step(1'b0, 32'h91001441, 5'h00);
    step(1'b1, 32'h91001441, 5'h00);
    step(1'b0, 32'h91001441, 5'h00);
    for (int i = 0; i < 400; i++) instr(gen_instr(), 5'($urandom));
    // undefined opcode parks the core
    instr(32'h00000000, 5'h00);
    for (int i = 0; i < 10; i++) step(1'b0, $urandom, 5'($urandom));
    step(1'b1, 32'h0, 5'h0);
    instr(32'h91001441, 5'h00);
    @(negedge clock);
    @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
